// File: rtl/game_timer_if.sv
// game_timer_if: control/status bundle between the game controller (master) and the
// round countdown timer (slave).
interface game_timer_if;
    logic       load;
    logic [7:0] load_sec_bcd;
    logic       start;
    logic       pause;
    logic [7:0] sec_bcd;
    logic [7:0] csec_bcd;
    logic       running;
    logic       expired;
    logic       timeout;
    logic       warn;

    modport master (
        output load, load_sec_bcd, start, pause,
        input  sec_bcd, csec_bcd, running, expired, timeout, warn
    );

    modport slave (
        input  load, load_sec_bcd, start, pause,
        output sec_bcd, csec_bcd, running, expired, timeout, warn
    );
endinterface

// File: rtl/game_timer.sv
// game_timer: BCD SS.cc countdown for a typing round.
// tick_in (asynchronous divided square wave) is synchronised and edge-detected into a
// one-cycle tick; every TICKS_PER_CSEC ticks in RUN the count drops by one centisecond.
// Reaching 00.00 enters DONE with a one-cycle timeout pulse.
// Optional feature: define TIMER_WARN_EN to drive warn when fewer than WARN_SEC whole
// seconds remain while running; otherwise warn is tied low.
module game_timer #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TICKS_PER_CSEC = 1,
    parameter int unsigned WARN_SEC       = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_in,
    game_timer_if.slave bus
);

    // Elaboration-time parameter sanity checks.
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("game_timer: SYNC_STAGES must be >= 2");
    end
    if (TICKS_PER_CSEC < 1) begin : g_bad_ticks
        $error("game_timer: TICKS_PER_CSEC must be >= 1");
    end
    if (WARN_SEC > 99) begin : g_bad_warn
        $error("game_timer: WARN_SEC must fit in two BCD digits");
    end

    localparam int unsigned PW = (TICKS_PER_CSEC > 1) ? $clog2(TICKS_PER_CSEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_CSEC - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPause,
        StDone
    } state_e;

    state_e                 state_q, state_d;
    logic [7:0]             sec_q, sec_d;
    logic [7:0]             csec_q, csec_d;
    logic [PW-1:0]          presc_q, presc_d;
    logic                   running_q;
    logic                   expired_q;
    logic                   timeout_q;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   tick_prev_q;
    logic                   tick;

    logic [7:0]             dec_sec;
    logic [7:0]             dec_csec;
    logic                   time_zero;
    logic                   dec_zero;

    // A digit above 9 loads as 9 so the counters only ever hold valid BCD.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    // Synchroniser chain plus previous-value register for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            tick_prev_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], tick_in};
            tick_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign tick = sync_q[SYNC_STAGES-1] & ~tick_prev_q;

    // One-centisecond BCD decrement with borrow from csec tens and then seconds.
    always_comb begin
        dec_sec  = sec_q;
        dec_csec = csec_q;
        if (time_zero) begin
            // Never wrap below 00.00.
            dec_sec  = sec_q;
            dec_csec = csec_q;
        end else if (csec_q[3:0] != 4'd0) begin
            dec_csec[3:0] = csec_q[3:0] - 4'd1;
        end else if (csec_q[7:4] != 4'd0) begin
            dec_csec = {csec_q[7:4] - 4'd1, 4'd9};
        end else begin
            dec_csec = 8'h99;
            if (sec_q[3:0] != 4'd0) begin
                dec_sec[3:0] = sec_q[3:0] - 4'd1;
            end else begin
                dec_sec = {sec_q[7:4] - 4'd1, 4'd9};
            end
        end
    end

    assign time_zero = (sec_q == 8'h00) && (csec_q == 8'h00);
    assign dec_zero  = (dec_sec == 8'h00) && (dec_csec == 8'h00);

    // Next-state: load beats start beats pause beats tick.
    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        csec_d  = csec_q;
        presc_d = presc_q;
        if (bus.load) begin
            state_d = StIdle;
            sec_d   = {clamp_digit(bus.load_sec_bcd[7:4]), clamp_digit(bus.load_sec_bcd[3:0])};
            csec_d  = 8'h00;
            presc_d = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_d = time_zero ? StDone : StRun;
                    end
                end
                StRun: begin
                    // start is a no-op in RUN but still outranks a coincident pause.
                    if (bus.pause && !bus.start) begin
                        state_d = StPause;
                    end else if (tick) begin
                        if (presc_q == PRESC_LAST) begin
                            presc_d = '0;
                            sec_d   = dec_sec;
                            csec_d  = dec_csec;
                            if (dec_zero) begin
                                state_d = StDone;
                            end
                        end else begin
                            presc_d = presc_q + 1'b1;
                        end
                    end
                end
                StPause: begin
                    if (bus.start) begin
                        state_d = StRun;
                    end
                end
                StDone: begin
                    state_d = StDone;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State, counts and registered status decodes all update on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            sec_q     <= 8'h00;
            csec_q    <= 8'h00;
            presc_q   <= '0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sec_q     <= sec_d;
            csec_q    <= csec_d;
            presc_q   <= presc_d;
            running_q <= (state_d == StRun);
            expired_q <= (state_d == StDone);
            timeout_q <= (state_d == StDone) && (state_q != StDone);
        end
    end

    assign bus.sec_bcd  = sec_q;
    assign bus.csec_bcd = csec_q;
    assign bus.running  = running_q;
    assign bus.expired  = expired_q;
    assign bus.timeout  = timeout_q;

`ifdef TIMER_WARN_EN
    // Valid two-digit BCD compares numerically, so a plain byte compare suffices.
    localparam logic [7:0] WARN_BCD = {4'(WARN_SEC / 10), 4'(WARN_SEC % 10)};

    logic warn_q;

    // Warning flag tracks the next counts so it changes with them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warn_q <= 1'b0;
        end else begin
            warn_q <= (state_d == StRun) && (sec_d < WARN_BCD);
        end
    end

    assign bus.warn = warn_q;
`else
    assign bus.warn = 1'b0;
`endif

endmodule

// File: tb/tb_game_timer.sv
// tb_game_timer: directed self-checking bench for game_timer (SYNC_STAGES=2,
// TICKS_PER_CSEC=1, WARN_SEC=5). Inputs change and outputs are sampled on negedge.
module tb_game_timer;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic tick_in = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    game_timer_if bus ();

    game_timer #(
        .SYNC_STAGES   (2),
        .TICKS_PER_CSEC(1),
        .WARN_SEC      (5)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_in(tick_in),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic pulse_load(input logic [7:0] v);
        bus.load_sec_bcd = v;
        bus.load         = 1'b1;
        @(negedge clk);
        bus.load         = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic pulse_pause();
        bus.pause = 1'b1;
        @(negedge clk);
        bus.pause = 1'b0;
    endtask

    // One full tick_in period; the count update is visible on return.
    task automatic tick_rise();
        tick_in = 1'b1;
        repeat (3) @(negedge clk);
        tick_in = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick_rise();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tick_in = ~tick_in;
        end
        vectors++;
        if ({bus.sec_bcd, bus.csec_bcd} !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_count: got %h exp 0000", {bus.sec_bcd, bus.csec_bcd});
        end
        vectors++;
        if ({bus.running, bus.expired, bus.timeout, bus.warn} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_status: got %b exp 0000",
                     {bus.running, bus.expired, bus.timeout, bus.warn});
        end
        tick_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        tick_rise();
        vectors++;
        if ({bus.sec_bcd, bus.csec_bcd, bus.running, bus.expired} !== 18'h0) begin
            miscompares++;
            $display("FAIL idle_after_reset: got %h/%b exp 0000/00",
                     {bus.sec_bcd, bus.csec_bcd}, {bus.running, bus.expired});
        end
    endtask

    task automatic test_countdown();
        pulse_load(8'h02);
        vectors++;
        if ({bus.sec_bcd, bus.csec_bcd} !== 16'h0200 || bus.running !== 1'b0) begin
            miscompares++;
            $display("FAIL load_02: got %h run %b exp 0200 run 0",
                     {bus.sec_bcd, bus.csec_bcd}, bus.running);
        end
        pulse_start();
        vectors++;
        if (bus.running !== 1'b1) begin
            miscompares++;
            $display("FAIL start_run: got running %b exp 1", bus.running);
        end
        // Latency: unchanged two cycles after the rise, updated on the third.
        tick_in = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus.sec_bcd, bus.csec_bcd} !== 16'h0200) begin
            miscompares++;
            $display("FAIL tick_latency_early: got %h exp 0200", {bus.sec_bcd, bus.csec_bcd});
        end
        @(negedge clk);
        vectors++;
        if ({bus.sec_bcd, bus.csec_bcd} !== 16'h0199) begin
            miscompares++;
            $display("FAIL tick_latency_due: got %h exp 0199", {bus.sec_bcd, bus.csec_bcd});
        end
        // Falling edge must not count.
        tick_in = 1'b0;
        repeat (4) @(negedge clk);
        vectors++;
        if ({bus.sec_bcd, bus.csec_bcd} !== 16'h0199) begin
            miscompares++;
            $display("FAIL falling_ignored: got %h exp 0199", {bus.sec_bcd, bus.csec_bcd});
        end
        ticks(2);
        vectors++;
        if ({bus.sec_bcd, bus.csec_bcd} !== 16'h0197) begin
            miscompares++;
            $display("FAIL three_ticks: got %h exp 0197", {bus.sec_bcd, bus.csec_bcd});
        end
        ticks(7);
        vectors++;
        if ({bus.sec_bcd, bus.csec_bcd} !== 16'h0190) begin
            miscompares++;
            $display("FAIL tens_borrow: got %h exp 0190", {bus.sec_bcd, bus.csec_bcd});
        end
    endtask

    task automatic test_expire();
        pulse_load(8'h01);
        pulse_start();
        ticks(99);
        vectors++;
        if ({bus.sec_bcd, bus.csec_bcd} !== 16'h0001 || bus.running !== 1'b1) begin
            miscompares++;
            $display("FAIL before_expire: got %h run %b exp 0001 run 1",
                     {bus.sec_bcd, bus.csec_bcd}, bus.running);
        end
        tick_in = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.timeout !== 1'b0 || bus.expired !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_early: got to %b exp 0 exp'd %b exp 0", bus.timeout, bus.expired);
        end
        @(negedge clk);
        vectors++;
        if ({bus.sec_bcd, bus.csec_bcd} !== 16'h0000 ||
            {bus.timeout, bus.expired, bus.running} !== 3'b110) begin
            miscompares++;
            $display("FAIL expire_edge: got %h t/e/r %b exp 0000 110",
                     {bus.sec_bcd, bus.csec_bcd}, {bus.timeout, bus.expired, bus.running});
        end
        @(negedge clk);
        vectors++;
        if (bus.timeout !== 1'b0 || bus.expired !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_one_cycle: got t/e %b%b exp 01", bus.timeout, bus.expired);
        end
        tick_in = 1'b0;
        repeat (3) @(negedge clk);
        tick_rise();
        pulse_start();
        pulse_pause();
        tick_rise();
        vectors++;
        if ({bus.sec_bcd, bus.csec_bcd} !== 16'h0000 ||
            {bus.timeout, bus.expired, bus.running} !== 3'b010) begin
            miscompares++;
            $display("FAIL done_hold: got %h t/e/r %b exp 0000 010",
                     {bus.sec_bcd, bus.csec_bcd}, {bus.timeout, bus.expired, bus.running});
        end
    endtask

    task automatic test_pause();
        pulse_load(8'h05);
        pulse_start();
        pulse_pause();
        vectors++;
        if (bus.running !== 1'b0 || bus.expired !== 1'b0) begin
            miscompares++;
            $display("FAIL pause_state: got r/e %b%b exp 00", bus.running, bus.expired);
        end
        ticks(10);
        vectors++;
        if ({bus.sec_bcd, bus.csec_bcd} !== 16'h0500) begin
            miscompares++;
            $display("FAIL pause_hold: got %h exp 0500", {bus.sec_bcd, bus.csec_bcd});
        end
        pulse_start();
        tick_rise();
        vectors++;
        if ({bus.sec_bcd, bus.csec_bcd} !== 16'h0499 || bus.running !== 1'b1) begin
            miscompares++;
            $display("FAIL resume_tick: got %h run %b exp 0499 run 1",
                     {bus.sec_bcd, bus.csec_bcd}, bus.running);
        end
    endtask

    task automatic test_load_tick_collision();
        pulse_load(8'h03);
        pulse_start();
        // Line the load up with the cycle in which the synchronised tick is live.
        tick_in = 1'b1;
        repeat (2) @(negedge clk);
        pulse_load(8'h0A);
        vectors++;
        if ({bus.sec_bcd, bus.csec_bcd} !== 16'h0900 || bus.running !== 1'b0) begin
            miscompares++;
            $display("FAIL load_beats_tick: got %h run %b exp 0900 run 0",
                     {bus.sec_bcd, bus.csec_bcd}, bus.running);
        end
        tick_in = 1'b0;
        repeat (3) @(negedge clk);
        tick_rise();
        vectors++;
        if ({bus.sec_bcd, bus.csec_bcd} !== 16'h0900) begin
            miscompares++;
            $display("FAIL idle_ignores_tick: got %h exp 0900", {bus.sec_bcd, bus.csec_bcd});
        end
        pulse_load(8'hF3);
        vectors++;
        if (bus.sec_bcd !== 8'h93) begin
            miscompares++;
            $display("FAIL clamp_tens: got %h exp 93", bus.sec_bcd);
        end
        pulse_load(8'h00);
        pulse_start();
        vectors++;
        if ({bus.timeout, bus.expired, bus.running} !== 3'b110) begin
            miscompares++;
            $display("FAIL start_at_zero: got t/e/r %b exp 110",
                     {bus.timeout, bus.expired, bus.running});
        end
        @(negedge clk);
        vectors++;
        if ({bus.timeout, bus.expired} !== 2'b01) begin
            miscompares++;
            $display("FAIL zero_timeout_width: got t/e %b exp 01", {bus.timeout, bus.expired});
        end
    endtask

    task automatic test_back_to_back();
        pulse_load(8'h02);
        pulse_start();
        pulse_pause();
        bus.start = 1'b1;
        bus.pause = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.running !== 1'b1) begin
            miscompares++;
            $display("FAIL start_beats_pause_in_pause: got running %b exp 1", bus.running);
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.pause = 1'b0;
        vectors++;
        if (bus.running !== 1'b1) begin
            miscompares++;
            $display("FAIL start_beats_pause_in_run: got running %b exp 1", bus.running);
        end
    endtask

    task automatic test_warn();
        logic exp_warn;
`ifdef TIMER_WARN_EN
        exp_warn = 1'b1;
`else
        exp_warn = 1'b0;
`endif
        pulse_load(8'h05);
        pulse_start();
        vectors++;
        if (bus.warn !== 1'b0) begin
            miscompares++;
            $display("FAIL warn_at_5s: got %b exp 0", bus.warn);
        end
        tick_rise();
        vectors++;
        if (bus.warn !== exp_warn || bus.sec_bcd !== 8'h04) begin
            miscompares++;
            $display("FAIL warn_below_5s: got %b sec %h exp %b sec 04",
                     bus.warn, bus.sec_bcd, exp_warn);
        end
        pulse_pause();
        vectors++;
        if (bus.warn !== 1'b0) begin
            miscompares++;
            $display("FAIL warn_paused: got %b exp 0", bus.warn);
        end
        pulse_start();
        vectors++;
        if (bus.warn !== exp_warn) begin
            miscompares++;
            $display("FAIL warn_resumed: got %b exp %b", bus.warn, exp_warn);
        end
        pulse_load(8'h09);
        vectors++;
        if (bus.warn !== 1'b0) begin
            miscompares++;
            $display("FAIL warn_idle: got %b exp 0", bus.warn);
        end
    endtask

    task automatic test_async_reset();
        pulse_load(8'h03);
        pulse_start();
        ticks(2);
        vectors++;
        if ({bus.sec_bcd, bus.csec_bcd} !== 16'h0298) begin
            miscompares++;
            $display("FAIL pre_reset_count: got %h exp 0298", {bus.sec_bcd, bus.csec_bcd});
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.sec_bcd, bus.csec_bcd} !== 16'h0000 ||
            {bus.running, bus.expired, bus.timeout, bus.warn} !== 4'b0000) begin
            miscompares++;
            $display("FAIL async_reset: got %h status %b exp 0000 0000",
                     {bus.sec_bcd, bus.csec_bcd},
                     {bus.running, bus.expired, bus.timeout, bus.warn});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus.timeout, bus.expired, bus.running} !== 3'b000 ||
            {bus.sec_bcd, bus.csec_bcd} !== 16'h0000) begin
            miscompares++;
            $display("FAIL post_reset_idle: got %h t/e/r %b exp 0000 000",
                     {bus.sec_bcd, bus.csec_bcd}, {bus.timeout, bus.expired, bus.running});
        end
    endtask

    initial begin
        bus.load         = 1'b0;
        bus.load_sec_bcd = 8'h00;
        bus.start        = 1'b0;
        bus.pause        = 1'b0;
        test_reset();
        test_countdown();
        test_expire();
        test_pause();
        test_load_tick_collision();
        test_back_to_back();
        test_warn();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
